// File: rtl/display_pkg.sv
// Shared display-controller constants: frame geometry, index-memory widths, write-arbiter states.
// Pure definitions: no logic, no latency, no flow control.
package display_pkg;

  localparam int FRAME_W       = 640;
  localparam int FRAME_H       = 480;
  localparam int FRAME_DEPTH   = FRAME_W * FRAME_H;
  localparam int INDEX_AW      = 19;
  localparam int INDEX_DW      = 3;
  localparam int ARB_NREQ      = 3;
  localparam int ARB_MAX_BURST = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_CLEAR = 2'd2
  } arb_state_e;

  // Round-robin successor of a requester index.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/index_write_arbiter_if.sv
// Writer-side request bus and index-memory write port of the frame write arbiter.
// Grant is a beat-accept strobe: a writer holds req/addr/data until its beat is granted.
interface index_write_arbiter_if
  import display_pkg::*;
#(
  parameter int NREQ = ARB_NREQ,
  parameter int AW   = INDEX_AW,
  parameter int DW   = INDEX_DW
);
  logic [NREQ-1:0]    req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    grant;
  logic [AW-1:0]      mem_waddr;
  logic [DW-1:0]      mem_wdata;
  logic               mem_wenable;

  modport master (
    output req, req_addr, req_data, req_last,
    input  grant, mem_waddr, mem_wdata, mem_wenable
  );

  modport slave (
    input  req, req_addr, req_data, req_last,
    output grant, mem_waddr, mem_wdata, mem_wenable
  );
endinterface

// File: rtl/rr_priority_select.sv
// Combinational round-robin picker: first asserted request scanning upward from ptr, with wrap.
// Zero latency; no flow control, winner is zero when no request is asserted.
module rr_priority_select #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic [PW-1:0] winner_idx,
  output logic          any
);

  logic [PW:0]   slot;
  logic [PW-1:0] cand;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    any        = 1'b0;
    slot       = '0;
    cand       = '0;
    for (int k = 0; k < N; k++) begin
      slot = {1'b0, ptr} + (PW + 1)'(k);
      if (slot >= (PW + 1)'(N)) begin
        slot = slot - (PW + 1)'(N);
      end
      cand = slot[PW-1:0];
      if (!any && req[cand]) begin
        any          = 1'b1;
        winner_idx   = cand;
        winner[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/index_write_arbiter.sv
// Shares the frame-index write port between NREQ burst writers (round robin) and a full-frame clear sweep.
// Granted beat appears on mem_* one cycle later; writers stall on grant=0, and a clear waits for the current burst.
module index_write_arbiter
  import display_pkg::*;
#(
  parameter int NREQ      = ARB_NREQ,
  parameter int AW        = INDEX_AW,
  parameter int DW        = INDEX_DW,
  parameter int DEPTH     = FRAME_DEPTH,
  parameter int MAX_BURST = ARB_MAX_BURST
) (
  input  logic                 clock,
  input  logic                 reset,
  index_write_arbiter_if.slave bus,
  input  logic                 clear_start,
  input  logic [DW-1:0]        clear_index,
  output logic                 clear_busy,
  output logic [NREQ-1:0]      owner
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  arb_state_e      state_q, state_d;
  logic [NREQ-1:0] owner_q, owner_d;
  logic [PW-1:0]   owner_idx_q, owner_idx_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            clear_pending_q, clear_pending_d;
  logic            clear_busy_q, clear_busy_d;
  logic [DW-1:0]   clear_idx_q, clear_idx_d;
  logic [AW-1:0]   clear_cnt_q, clear_cnt_d;
  logic [AW-1:0]   mem_waddr_q, mem_waddr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
  logic            mem_wenable_q, mem_wenable_d;

  logic [NREQ-1:0] pick_oh;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;
  logic            owner_req, owner_last, clear_accept, rel;
  logic [AW-1:0]   owner_addr;
  logic [DW-1:0]   owner_data;
  logic [NREQ-1:0] grant_c;

  rr_priority_select #(.N(NREQ), .PW(PW)) u_pick (
    .req        (bus.req),
    .ptr        (rr_ptr_q),
    .winner     (pick_oh),
    .winner_idx (pick_idx),
    .any        (pick_any)
  );

  always_comb begin
    owner_req  = 1'b0;
    owner_last = 1'b0;
    owner_addr = '0;
    owner_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner_idx_q == PW'(i)) begin
        owner_req  = bus.req[i];
        owner_last = bus.req_last[i];
        owner_addr = bus.req_addr[i*AW +: AW];
        owner_data = bus.req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    owner_idx_d     = owner_idx_q;
    rr_ptr_d        = rr_ptr_q;
    beat_cnt_d      = beat_cnt_q;
    clear_pending_d = clear_pending_q;
    clear_busy_d    = clear_busy_q;
    clear_idx_d     = clear_idx_q;
    clear_cnt_d     = clear_cnt_q;
    mem_waddr_d     = mem_waddr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_wenable_d   = 1'b0;
    grant_c         = '0;
    rel             = 1'b0;

    // A clear is taken at most once until its sweep ends; later pulses are dropped.
    clear_accept = clear_start && !clear_busy_q && !clear_pending_q;
    if (clear_accept) begin
      clear_idx_d  = clear_index;
      clear_busy_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (clear_pending_q || clear_accept) begin
          state_d         = ST_CLEAR;
          clear_cnt_d     = '0;
          clear_pending_d = 1'b0;
        end else if (pick_any) begin
          state_d     = ST_BURST;
          owner_d     = pick_oh;
          owner_idx_d = pick_idx;
        end
      end

      ST_BURST: begin
        if (clear_accept) begin
          clear_pending_d = 1'b1;
        end
        if (owner_req) begin
          grant_c       = owner_q;
          mem_waddr_d   = owner_addr;
          mem_wdata_d   = owner_data;
          mem_wenable_d = 1'b1;
          beat_cnt_d    = beat_cnt_q + 1'b1;
          rel           = owner_last || (beat_cnt_q == BW'(MAX_BURST - 1));
        end else begin
          rel = 1'b1;
        end
        if (rel) begin
          state_d    = ST_IDLE;
          owner_d    = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = PW'(rr_next(32'(owner_idx_q), NREQ));
        end
      end

      ST_CLEAR: begin
        mem_waddr_d   = clear_cnt_q;
        mem_wdata_d   = clear_idx_q;
        mem_wenable_d = 1'b1;
        clear_cnt_d   = clear_cnt_q + 1'b1;
        if (clear_cnt_q == AW'(DEPTH - 1)) begin
          state_d      = ST_IDLE;
          clear_busy_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      owner_q         <= '0;
      owner_idx_q     <= '0;
      rr_ptr_q        <= '0;
      beat_cnt_q      <= '0;
      clear_pending_q <= 1'b0;
      clear_busy_q    <= 1'b0;
      clear_idx_q     <= '0;
      clear_cnt_q     <= '0;
      mem_waddr_q     <= '0;
      mem_wdata_q     <= '0;
      mem_wenable_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      owner_q         <= owner_d;
      owner_idx_q     <= owner_idx_d;
      rr_ptr_q        <= rr_ptr_d;
      beat_cnt_q      <= beat_cnt_d;
      clear_pending_q <= clear_pending_d;
      clear_busy_q    <= clear_busy_d;
      clear_idx_q     <= clear_idx_d;
      clear_cnt_q     <= clear_cnt_d;
      mem_waddr_q     <= mem_waddr_d;
      mem_wdata_q     <= mem_wdata_d;
      mem_wenable_q   <= mem_wenable_d;
    end
  end

  assign bus.grant       = grant_c;
  assign bus.mem_waddr   = mem_waddr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_wenable = mem_wenable_q;
  assign clear_busy      = clear_busy_q;
  assign owner           = owner_q;

endmodule
